// File: rtl/srff_bank_pkg.sv
// Shared definitions for the SR flip-flop bank: conflict-resolution mode encoding.
package srff_pkg;

  typedef logic [1:0] srff_mode_t;

  localparam srff_mode_t SRFF_MODE_HOLD = 2'd0;
  localparam srff_mode_t SRFF_MODE_SET  = 2'd1;
  localparam srff_mode_t SRFF_MODE_RST  = 2'd2;
  localparam srff_mode_t SRFF_MODE_TOG  = 2'd3;

  // Next state of one SR bit for a given request pair and conflict mode.
  function automatic logic srff_next(input logic q, input logic s, input logic r,
                                     input srff_mode_t mode);
    logic nq;
    nq = q;
    unique case ({s, r})
      2'b00: nq = q;
      2'b01: nq = 1'b0;
      2'b10: nq = 1'b1;
      default: begin
        unique case (mode)
          SRFF_MODE_HOLD: nq = q;
          SRFF_MODE_SET:  nq = 1'b1;
          SRFF_MODE_RST:  nq = 1'b0;
          default:        nq = ~q;
        endcase
      end
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/srff_bank_if.sv
// Request/status bundle of the SR flip-flop bank.
interface srff_bank_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             en;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] r;
  logic             clr_sticky;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_bar;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] conflict;
  logic [CNT_W-1:0] conflict_cnt;

  modport master (
    output en, s, r, clr_sticky,
    input  q, q_bar, rise, fall, conflict, conflict_cnt
  );

  modport slave (
    input  en, s, r, clr_sticky,
    output q, q_bar, rise, fall, conflict, conflict_cnt
  );
endinterface

// File: rtl/srff_bank_cell.sv
// One SR bit: state, registered edge pulses and sticky conflict flag.
module srff_cell
  import srff_pkg::*;
#(
  parameter srff_mode_t MODE = SRFF_MODE_HOLD
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic s,
  input  logic r,
  input  logic clr_sticky,
  input  logic init_val,
  output logic q,
  output logic rise,
  output logic fall,
  output logic conflict_hit,
  output logic conflict
);

  logic q_nxt;

  // Resolve the request pair into the next state and flag an enabled conflict.
  always_comb begin
    q_nxt        = srff_next(q, s, r, MODE);
    conflict_hit = en & s & r;
  end

  // State and edge pulses; pulses are dropped on disabled edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q    <= init_val;
      rise <= 1'b0;
      fall <= 1'b0;
    end else if (en) begin
      q    <= q_nxt;
      rise <= q_nxt & ~q;
      fall <= ~q_nxt & q;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
    end
  end

  // Sticky conflict flag; a fresh conflict beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conflict <= 1'b0;
    end else if (conflict_hit) begin
      conflict <= 1'b1;
    end else if (clr_sticky) begin
      conflict <= 1'b0;
    end
  end

endmodule

// File: rtl/srff_bank.sv
// Bank of WIDTH SR flip-flops with enable, conflict mode and saturating conflict counter.
module srff_bank
  import srff_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter int               MODE  = 0,
  parameter logic [WIDTH-1:0] INIT  = '0,
  parameter int               CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  srff_bank_if.slave  bus
);

  if (MODE < 0 || MODE > 3) begin : g_bad_mode
    $fatal(1, "srff_bank: MODE must be 0..3");
  end
  if (WIDTH < 1) begin : g_bad_width
    $fatal(1, "srff_bank: WIDTH must be >= 1");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $fatal(1, "srff_bank: CNT_W must be >= 1");
  end

  localparam srff_mode_t       CELL_MODE = srff_mode_t'(MODE);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [WIDTH-1:0] q_int;
  logic [WIDTH-1:0] rise_int;
  logic [WIDTH-1:0] fall_int;
  logic [WIDTH-1:0] hit_int;
  logic [WIDTH-1:0] conflict_int;
  logic [CNT_W-1:0] cnt;
  logic             any_hit;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    srff_cell #(.MODE(CELL_MODE)) u_cell (
      .clk          (clk),
      .rst          (rst),
      .en           (bus.en),
      .s            (bus.s[i]),
      .r            (bus.r[i]),
      .clr_sticky   (bus.clr_sticky),
      .init_val     (INIT[i]),
      .q            (q_int[i]),
      .rise         (rise_int[i]),
      .fall         (fall_int[i]),
      .conflict_hit (hit_int[i]),
      .conflict     (conflict_int[i])
    );
  end

  // Any bit in conflict this cycle (already qualified by en inside the cells).
  always_comb begin
    any_hit = |hit_int;
  end

  // Conflict-cycle counter: saturates, clear plus conflict restarts at one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (any_hit) begin
      if (bus.clr_sticky) begin
        cnt <= CNT_W'(1);
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end
    end else if (bus.clr_sticky) begin
      cnt <= '0;
    end
  end

  assign bus.q            = q_int;
  assign bus.q_bar        = ~q_int;
  assign bus.rise         = rise_int;
  assign bus.fall         = fall_int;
  assign bus.conflict     = conflict_int;
  assign bus.conflict_cnt = cnt;

endmodule
